// File: rtl/ad7476_decim_packer.sv
// Boxcar-averages 2^LOG2_N paired AD7476 samples per channel and queues
// {seq, avg1, avg0} words on a valid/ready stream through a 2-entry FWFT FIFO.
module ad7476_decim_packer #(
  parameter int LOG2_N = 3
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        en,
  input  logic [11:0] adc_res0,
  input  logic [11:0] adc_res1,
  input  logic        adc_valid,
  output logic [31:0] m_data,
  output logic        m_valid,
  input  logic        m_ready,
  output logic        overflow,
  input  logic        clr_overflow
);

  localparam int ACC_W = 12 + LOG2_N;
  localparam int N     = 1 << LOG2_N;
  localparam int CNT_W = (LOG2_N > 0) ? LOG2_N : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(N - 1);

  logic [ACC_W-1:0] acc0_reg, acc1_reg;
  logic [ACC_W-1:0] sum0, sum1;
  logic [CNT_W-1:0] cnt_reg;
  logic [7:0]       seq_reg;
  logic [11:0]      avg0, avg1;
  logic [31:0]      word;
  logic             sample, last;

  logic [31:0] mem_reg [2];
  logic        wr_ptr_reg, rd_ptr_reg;
  logic [1:0]  count_reg;
  logic        full, pop, wr_ok, drop;

  assign sum0   = acc0_reg + ACC_W'(adc_res0);
  assign sum1   = acc1_reg + ACC_W'(adc_res1);
  // Truncating divide by N: drop the low LOG2_N bits of the full sum.
  assign avg0   = sum0[ACC_W-1:LOG2_N];
  assign avg1   = sum1[ACC_W-1:LOG2_N];
  assign word   = {seq_reg, avg1, avg0};
  assign sample = en & adc_valid;
  assign last   = sample & (cnt_reg == CNT_LAST);

  always_ff @(posedge clk) begin
    if (rst) begin
      acc0_reg <= '0;
      acc1_reg <= '0;
      cnt_reg  <= '0;
      seq_reg  <= '0;
    end else if (!en) begin
      acc0_reg <= '0;
      acc1_reg <= '0;
      cnt_reg  <= '0;
    end else if (adc_valid) begin
      if (last) begin
        acc0_reg <= '0;
        acc1_reg <= '0;
        cnt_reg  <= '0;
        // Advances even when the word is dropped so the gap is visible downstream.
        seq_reg  <= seq_reg + 8'd1;
      end else begin
        acc0_reg <= sum0;
        acc1_reg <= sum1;
        cnt_reg  <= cnt_reg + CNT_W'(1);
      end
    end
  end

  assign full    = (count_reg == 2'd2);
  assign m_valid = (count_reg != 2'd0);
  assign pop     = m_valid & m_ready;
  // A full FIFO still accepts a push when the head leaves in the same cycle.
  assign wr_ok   = last & (~full | pop);
  assign drop    = last & full & ~pop;
  assign m_data  = mem_reg[rd_ptr_reg];

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 2; i++) mem_reg[i] <= '0;
      wr_ptr_reg <= 1'b0;
      rd_ptr_reg <= 1'b0;
      count_reg  <= 2'd0;
      overflow   <= 1'b0;
    end else begin
      if (wr_ok) begin
        mem_reg[wr_ptr_reg] <= word;
        wr_ptr_reg          <= ~wr_ptr_reg;
      end
      if (pop) rd_ptr_reg <= ~rd_ptr_reg;
      count_reg <= count_reg + 2'(wr_ok) - 2'(pop);
      if (drop)              overflow <= 1'b1;
      else if (clr_overflow) overflow <= 1'b0;
    end
  end

endmodule

// File: tb/tb_ad7476_decim_packer.sv
// Bench for ad7476_decim_packer: two instances (LOG2_N=3 and LOG2_N=0), each
// checked every cycle against a sample-list/queue model plus literal word checks.
module tb_ad7476_decim_packer;

  logic        clk = 1'b0;
  logic        rst [2];
  logic        en [2];
  logic [11:0] adc_res0 [2];
  logic [11:0] adc_res1 [2];
  logic        adc_valid [2];
  logic [31:0] m_data [2];
  logic        m_valid [2];
  logic        m_ready [2];
  logic        overflow [2];
  logic        clr_overflow [2];

  int errors = 0;
  int checks = 0;
  logic [31:0] got3 [$];
  logic [31:0] got0 [$];

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %08h expected %08h at %0t", name, act, exp, $time);
    end
  endtask

  for (genvar gi = 0; gi < 2; gi++) begin : g
    localparam int L = (gi == 0) ? 3 : 0;
    localparam int N = 1 << L;

    ad7476_decim_packer #(.LOG2_N(L)) dut (
      .clk(clk), .rst(rst[gi]), .en(en[gi]),
      .adc_res0(adc_res0[gi]), .adc_res1(adc_res1[gi]), .adc_valid(adc_valid[gi]),
      .m_data(m_data[gi]), .m_valid(m_valid[gi]), .m_ready(m_ready[gi]),
      .overflow(overflow[gi]), .clr_overflow(clr_overflow[gi])
    );

    int          samp0 [$];
    int          samp1 [$];
    logic [31:0] mq [$];
    logic        movf = 1'b0;
    logic [7:0]  mseq = 8'd0;

    // Model: collect N samples, average by integer division, queue up to 2 words.
    always @(posedge clk) begin
      logic pop, push, dropped;
      logic [31:0] w;
      int s0, s1;
      pop = (mq.size() > 0) && m_ready[gi];
      push = 1'b0;
      dropped = 1'b0;
      w = '0;
      if (!rst[gi] && m_valid[gi] && m_ready[gi]) begin
        if (gi == 0) got3.push_back(m_data[gi]);
        else         got0.push_back(m_data[gi]);
        $display("ch%0d L=%0d word %08h", gi, L, m_data[gi]);
      end
      if (rst[gi]) begin
        samp0.delete(); samp1.delete(); mq.delete();
        movf = 1'b0; mseq = 8'd0;
      end else begin
        if (!en[gi]) begin
          samp0.delete(); samp1.delete();
        end else if (adc_valid[gi]) begin
          samp0.push_back(int'(adc_res0[gi]));
          samp1.push_back(int'(adc_res1[gi]));
          if (samp0.size() == N) begin
            s0 = 0; s1 = 0;
            foreach (samp0[k]) s0 += samp0[k];
            foreach (samp1[k]) s1 += samp1[k];
            w = {mseq, 12'(s1 / N), 12'(s0 / N)};
            mseq = mseq + 8'd1;
            push = 1'b1;
            samp0.delete(); samp1.delete();
          end
        end
        if (pop) void'(mq.pop_front());
        if (push) begin
          if (mq.size() == 2) dropped = 1'b1;
          else mq.push_back(w);
        end
        if (dropped) movf = 1'b1;
        else if (clr_overflow[gi]) movf = 1'b0;
      end
    end

    always @(negedge clk) begin
      check($sformatf("ch%0d m_valid", gi), 32'(m_valid[gi]), 32'(mq.size() != 0));
      if (mq.size() != 0) check($sformatf("ch%0d m_data", gi), m_data[gi], mq[0]);
      check($sformatf("ch%0d overflow", gi), 32'(overflow[gi]), 32'(movf));
    end
  end

  task automatic send(input int c, input logic [11:0] a, input logic [11:0] b);
    adc_valid[c] = 1'b1; adc_res0[c] = a; adc_res1[c] = b;
    @(negedge clk);
    adc_valid[c] = 1'b0;
  endtask

  task automatic pulse_rst(input int c);
    rst[c] = 1'b1;
    @(negedge clk);
    rst[c] = 1'b0;
  endtask

  initial begin
    for (int c = 0; c < 2; c++) begin
      rst[c] = 1'b1; en[c] = 1'b1; adc_res0[c] = '0; adc_res1[c] = '0;
      adc_valid[c] = 1'b0; m_ready[c] = 1'b1; clr_overflow[c] = 1'b0;
    end
    @(negedge clk);
    check("reset m_valid", 32'(m_valid[0]), 32'd0);
    check("reset m_data", m_data[0], 32'h0);
    check("reset overflow", 32'(overflow[0]), 32'd0);
    rst[0] = 1'b0; rst[1] = 1'b0;

    // Constant group, latency of m_valid.
    for (int i = 0; i < 7; i++) send(0, 12'h800, 12'h123);
    check("t1 pre-final m_valid", 32'(m_valid[0]), 32'd0);
    send(0, 12'h800, 12'h123);
    check("t1 m_valid", 32'(m_valid[0]), 32'd1);
    check("t1 word", m_data[0], 32'h00123800);
    check("t1 overflow", 32'(overflow[0]), 32'd0);
    repeat (2) @(negedge clk);

    // Ramp then constant group.
    pulse_rst(0);
    got3.delete();
    for (int i = 0; i < 8; i++) send(0, 12'(i), 12'hFFF);
    for (int i = 0; i < 8; i++) send(0, 12'h001, 12'h000);
    repeat (2) @(negedge clk);
    check("t2 count", 32'(got3.size()), 32'd2);
    if (got3.size() >= 2) begin
      check("t2 word0", got3[0], 32'h00FFF003);
      check("t2 word1", got3[1], 32'h01000001);
    end

    // Backpressure with overflow.
    pulse_rst(0);
    got3.delete();
    m_ready[0] = 1'b0;
    for (int gp = 0; gp < 3; gp++)
      for (int i = 0; i < 8; i++) send(0, 12'(16 * (gp + 1)), 12'h020);
    check("t3 overflow", 32'(overflow[0]), 32'd1);
    check("t3 head", m_data[0], 32'h00020010);
    m_ready[0] = 1'b1;
    repeat (3) @(negedge clk);
    check("t3 drained", 32'(got3.size()), 32'd2);
    if (got3.size() >= 2) begin
      check("t3 word0", got3[0], 32'h00020010);
      check("t3 word1", got3[1], 32'h01020020);
    end
    check("t3 empty", 32'(m_valid[0]), 32'd0);
    for (int i = 0; i < 8; i++) send(0, 12'h040, 12'h020);
    check("t3 seq gap word", m_data[0], 32'h03020040);
    check("t3 overflow sticky", 32'(overflow[0]), 32'd1);
    clr_overflow[0] = 1'b1;
    @(negedge clk);
    clr_overflow[0] = 1'b0;
    check("t3 overflow cleared", 32'(overflow[0]), 32'd0);

    // Reset mid-accumulation.
    pulse_rst(0);
    for (int i = 0; i < 5; i++) send(0, 12'hFFF, 12'hFFF);
    pulse_rst(0);
    check("t4 m_valid", 32'(m_valid[0]), 32'd0);
    check("t4 m_data", m_data[0], 32'h0);
    check("t4 overflow", 32'(overflow[0]), 32'd0);
    for (int i = 0; i < 8; i++) send(0, 12'h010, 12'h020);
    check("t4 word", m_data[0], 32'h00020010);

    // Enable toggling discards the partial group.
    pulse_rst(0);
    for (int i = 0; i < 4; i++) send(0, 12'h700, 12'h700);
    en[0] = 1'b0;
    for (int i = 0; i < 10; i++) send(0, 12'h555, 12'h555);
    en[0] = 1'b1;
    check("t5 no word while disabled", 32'(m_valid[0]), 32'd0);
    for (int i = 0; i < 7; i++) send(0, 12'h100, 12'h100);
    check("t5 no early word", 32'(m_valid[0]), 32'd0);
    send(0, 12'h100, 12'h100);
    check("t5 word", m_data[0], 32'h00100100);

    // LOG2_N=0: streaming with seq wrap.
    got0.delete();
    for (int i = 0; i < 300; i++) send(1, 12'(i), ~12'(i));
    repeat (2) @(negedge clk);
    check("t6 count", 32'(got0.size()), 32'd300);
    if (got0.size() == 300) begin
      check("t6 seq ff", 32'(got0[255][31:24]), 32'h000000FF);
      check("t6 seq wrap", 32'(got0[256][31:24]), 32'h00000000);
      check("t6 last word", got0[299], 32'h2BED412B);
    end
    check("t6 overflow", 32'(overflow[1]), 32'd0);

    // Full FIFO with simultaneous push and pop.
    m_ready[1] = 1'b0;
    send(1, 12'hAAA, 12'h111);
    send(1, 12'hBBB, 12'h222);
    got0.delete();
    for (int i = 0; i < 20; i++) begin
      m_ready[1] = 1'b1;
      send(1, 12'(i + 7), 12'(i * 3));
      m_ready[1] = 1'b0;
      @(negedge clk);
    end
    check("t7 overflow", 32'(overflow[1]), 32'd0);
    check("t7 still full-valid", 32'(m_valid[1]), 32'd1);
    check("t7 popped", 32'(got0.size()), 32'd20);
    if (got0.size() >= 1) check("t7 first popped", got0[0], 32'h2C111AAA);
    m_ready[1] = 1'b1;
    repeat (3) @(negedge clk);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/ad7476_decim_packer.md
Name: ad7476_decim_packer

Overview:
- Downstream consumer of the dual-channel AD7476 sampler.
- Takes paired 12-bit results plus their one-cycle valid strobe, and boxcar-averages 2^LOG2_N samples per channel.
- Packs each averaged pair with an 8-bit sequence number into a 32-bit word.
- Presents the words on a valid/ready stream through a 2-entry output FIFO, with sticky overflow reporting, for the capture/DMA logic.

Parameters:
- LOG2_N, 3, log2 of samples averaged per output word; legal range 0..8. N = 2^LOG2_N.
- ACC_W, 12+LOG2_N, accumulator width per channel. Derived; do not override.

Ports:
- clk  in  1  system clock (35 MHz domain shared with the sampler).
- rst  in  1  synchronous, active-high reset.
- en  in  1  averaging enable; low clears the accumulation and suppresses output generation.
- adc_res0  in  12  channel 0 sample; qualified by adc_valid.
- adc_res1  in  12  channel 1 sample; qualified by adc_valid.
- adc_valid  in  1  one-cycle strobe, sample pair valid. Back-to-back strobes are legal.
- m_data  out  32  {seq[7:0], avg1[11:0], avg0[11:0]}.
- m_valid  out  1  FIFO non-empty.
- m_ready  in  1  consumer accept; a word transfers on a clk edge with m_valid & m_ready.
- overflow  out  1  sticky; a result was dropped because the FIFO was full.
- clr_overflow  in  1  clears overflow. Set has priority if both occur in the same cycle.

Behaviour:
- Reset (rst=1 at a clk edge):
  - acc0, acc1 <= 0; cnt <= 0; seq <= 0.
  - FIFO emptied; m_valid=0; m_data=0; overflow=0.
  - Applies mid-accumulation and mid-stall; partial sums are discarded.
- en=0:
  - acc0, acc1, cnt held at 0; adc_valid ignored.
  - FIFO continues draining; seq held.
  - On en rising, accumulation starts fresh with the next adc_valid.
- Accumulation (en=1, adc_valid=1):
  - cnt < N-1: acc0 += adc_res0; acc1 += adc_res1 (zero-extended, ACC_W bits, cannot overflow); cnt++.
  - cnt == N-1 (final sample):
    - sum0 = acc0 + adc_res0; avg0 = sum0[ACC_W-1:LOG2_N], i.e. truncating divide by N. Same for avg1.
    - Form word {seq, avg1, avg0}; acc <= 0; cnt <= 0; seq <= seq+1 (wraps 255 -> 0).
    - Issue a push request in the same cycle.
  - LOG2_N=0: every adc_valid produces a word (pass-through with seq).
- Push timing:
  - The word is written into the FIFO at the clk edge that samples the final adc_valid.
  - m_valid rises in the cycle after that edge (latency 1 clk from the final strobe).
- FIFO (2 entries, first-word-fall-through):
  - m_data shows the head entry whenever m_valid=1.
  - m_data is held stable while m_valid & ~m_ready.
- Full with push and no pop:
  - New word dropped; overflow <= 1.
  - seq still advances, so the consumer sees the gap.
- Full with simultaneous push and pop: both occur; occupancy stays 2; no overflow.
- Empty with simultaneous push and pop: no pop is possible (m_valid=0); the push lands.
- Occupancy 1 with simultaneous push and pop: occupancy stays 1; the new word becomes head next cycle.
- Word order is strictly preserved; no word is duplicated.
- Must sustain adc_valid every cycle with m_ready held high: one word per N cycles, no drops.

Test Plan:
- LOG2_N=3, en=1, m_ready=1; 8 strobes of ch0=0x800, ch1=0x123 -> one word 0x00123800; m_valid high exactly 1 cycle after the 8th strobe edge; overflow=0.
- Ramp ch0=0..7, ch1=0xFFF constant over 8 strobes, then a second group of ch0=1 with ch1=0 -> first word avg0=0x003 (28>>3), avg1=0xFFF, seq=0x00; second word 0x01000001.
- Backpressure: m_ready=0, generate 3 groups -> FIFO holds seq 0x00 and 0x01, overflow=1, seq 0x02 word absent; raise m_ready -> exactly 2 words drained in order, m_valid drops. The next group emits seq=0x03. Then clr_overflow -> overflow=0.
- Reset mid-operation: after 5 of 8 strobes, pulse rst -> outputs zero next cycle. Next 8 strobes of 0x010/0x020 -> word 0x00020010, with no contribution from the pre-reset partial sum.
- en toggling: 4 strobes, en=0 for 10 cycles with strobes present, en=1, 8 strobes of 0x100 -> a single word with avg0=0x100, produced only after the 8 post-enable strobes.
- Seq wrap and full-duplex: LOG2_N=0, adc_valid every cycle for 300 cycles, m_ready=1 -> 300 words in order, seq wraps 0xFF -> 0x00, no overflow. Repeat with m_ready toggling every cycle and FIFO full -> simultaneous push/pop never sets overflow.
